// File: rtl/regfile_mp_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_mp_scoreboard
//   Decode-stage register file with two write ports, optional write-to-read
//   bypass, and a per-register pending-write scoreboard.
//
//   Port A (ALU writeback) has priority over port B (load writeback) when
//   both target the same register. Register 0 is hard-wired to zero and is
//   never marked pending. Register RST_IDX (if nonzero) resets to RST_VAL.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   rd_addr / rd_data   NUM_RD packed read ports (combinational)
//   rd_busy             per read port: addressed register has a pending write
//   wa_* / wb_*         write ports A (priority) and B
//   iss_en / iss_addr   mark a destination register as pending
//   busy_any            registered OR of all scoreboard bits
// ---------------------------------------------------------------------------
module regfile_mp_scoreboard #(
    parameter int                DATA_W  = 32,
    parameter int                ADDR_W  = 5,
    parameter int                NUM_RD  = 2,
    parameter int                RST_IDX = 9,
    parameter logic [DATA_W-1:0] RST_VAL = DATA_W'(100),
    parameter bit                BYPASS  = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     busy_any
);

    localparam int                DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] RST_A = ADDR_W'(RST_IDX);

    logic [DATA_W-1:0] regs      [DEPTH];
    logic [DATA_W-1:0] regs_next [DEPTH];
    logic [DEPTH-1:0]  sb;
    logic [DEPTH-1:0]  sb_next;

    // Port B is applied first so that port A overwrites it on a collision.
    always_comb begin
        regs_next = regs;
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_next[k] = '0;
            end
            if (RST_IDX != 0) begin
                regs_next[RST_A] = RST_VAL;
            end
        end else begin
            if (wb_en && (wb_addr != '0)) begin
                regs_next[wb_addr] = wb_data;
            end
            if (wa_en && (wa_addr != '0)) begin
                regs_next[wa_addr] = wa_data;
            end
        end
    end

    // Writes retire a pending entry; an issue in the same cycle re-arms it
    // because the newly issued producer is still outstanding.
    always_comb begin
        sb_next = sb;
        if (reset) begin
            sb_next = '0;
        end else begin
            if (wa_en) begin
                sb_next[wa_addr] = 1'b0;
            end
            if (wb_en) begin
                sb_next[wb_addr] = 1'b0;
            end
            if (iss_en) begin
                sb_next[iss_addr] = 1'b1;
            end
        end
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        regs     <= regs_next;
        sb       <= sb_next;
        busy_any <= |sb_next;
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rdat;
        logic              rbsy;

        assign ra = rd_addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            rdat = regs[ra];
            rbsy = sb[ra];
            if (ra == '0) begin
                rdat = '0;
                rbsy = 1'b0;
            end else if (BYPASS) begin
                if (wa_en && (wa_addr == ra)) begin
                    rdat = wa_data;
                    rbsy = 1'b0;
                end else if (wb_en && (wb_addr == ra)) begin
                    rdat = wb_data;
                    rbsy = 1'b0;
                end
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = rdat;
        assign rd_busy[i]                  = rbsy;
    end

endmodule
